// File: rtl/blackjack_pkg.sv
// Shared constants, FSM encoding and slot helpers for the card shoe.
package blackjack_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int RANKS_PER_SUIT = 13;
  localparam int LFSR_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_SEEK    = 2'd2,
    ST_DELIVER = 2'd3
  } shoe_state_t;

  // Fold the low six LFSR bits into the slot range 0..51.
  function automatic logic [5:0] start_slot(input logic [LFSR_W-1:0] lfsr);
    logic [5:0] raw;
    raw = lfsr[5:0];
    if (raw >= 6'(DECK_SIZE)) begin
      return raw - 6'(DECK_SIZE);
    end
    return raw;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] slot);
    return 4'(slot % 6'(RANKS_PER_SUIT)) + 4'd1;
  endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; reloads SEED on reset.
module shoe_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] value
);

  logic [15:0] value_reg;
  logic        feedback;

  assign feedback = value_reg[15] ^ value_reg[13] ^ value_reg[12] ^ value_reg[10];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_reg <= SEED;
    end else begin
      value_reg <= {value_reg[14:0], feedback};
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: deals ranks without replacement from a 52-slot used mask,
// picking a pseudo-random start slot and linearly probing for a free one.
module card_shoe #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       draw,
  input  logic       shuffle,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       empty
);

  import blackjack_pkg::*;

  shoe_state_t          state_reg, state_next;
  logic [DECK_SIZE-1:0] used_reg, used_next;
  logic [5:0]           ptr_reg, ptr_next;
  logic [5:0]           left_reg, left_next;
  logic [3:0]           card_reg, card_next;
  logic                 pending_reg, pending_next;
  logic [15:0]          lfsr;

  shoe_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .value  (lfsr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      used_reg    <= '0;
      ptr_reg     <= '0;
      left_reg    <= 6'(DECK_SIZE);
      card_reg    <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      used_reg    <= used_next;
      ptr_reg     <= ptr_next;
      left_reg    <= left_next;
      card_reg    <= card_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    used_next    = used_reg;
    ptr_next     = ptr_reg;
    left_next    = left_reg;
    card_next    = card_reg;
    pending_next = pending_reg;
    unique case (state_reg)
      ST_IDLE: begin
        // Shuffle wins over a simultaneous draw, which is simply dropped.
        if (shuffle) begin
          state_next   = ST_SHUFFLE;
          pending_next = 1'b0;
        end else if (draw) begin
          if (left_reg != 6'd0) begin
            ptr_next   = start_slot(lfsr);
            state_next = ST_SEEK;
          end else begin
            state_next   = ST_SHUFFLE;
            pending_next = 1'b1;
          end
        end
      end
      ST_SHUFFLE: begin
        used_next = '0;
        left_next = 6'(DECK_SIZE);
        if (pending_reg) begin
          ptr_next   = start_slot(lfsr);
          state_next = ST_SEEK;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SEEK: begin
        if (used_reg[ptr_reg]) begin
          ptr_next = (ptr_reg == 6'(DECK_SIZE - 1)) ? 6'd0 : ptr_reg + 6'd1;
        end else begin
          used_next[ptr_reg] = 1'b1;
          card_next          = rank_of(ptr_reg);
          left_next          = left_reg - 6'd1;
          state_next         = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        pending_next = 1'b0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    card       = card_reg;
    card_valid = (state_reg == ST_DELIVER);
    busy       = (state_reg != ST_IDLE);
    cards_left = left_reg;
    empty      = (left_reg == 6'd0);
  end

endmodule

// File: tb/tb_card_shoe.sv
// Randomized scoreboard bench for card_shoe against a slot-array reference model.
module tb_card_shoe;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       draw;
  logic       shuffle;
  logic [3:0] card;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       empty;

  card_shoe #(.SEED(SEED), .DECK_SIZE(52)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .draw       (draw),
    .shuffle    (shuffle),
    .card       (card),
    .card_valid (card_valid),
    .busy       (busy),
    .cards_left (cards_left),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int card;
    int left;
    int lat;
    int issue;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          obs_lat = 0;
  int          last_k = 0;
  int          hist[16];
  bit          m_used[52];
  int          m_left = 52;
  logic [15:0] m_lfsr = SEED;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int start_of(input logic [15:0] l);
    int v;
    v = int'(l) % 64;
    if (v >= 52) v -= 52;
    return v;
  endfunction

  task automatic model_clear();
    foreach (m_used[i]) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  // Reference LFSR and cycle counter, advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!resetn) m_lfsr = SEED;
      else         m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Monitor: pops one expectation per card_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && card_valid === 1'b1) begin
        pulses++;
        hist[card]++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          obs_lat = cyc - e.issue;
          $display("deal card=%0d left=%0d latency=%0d", card, cards_left, obs_lat);
          chk("card", int'(card), e.card);
          chk("cards_left", int'(cards_left), e.left);
          chk("latency", obs_lat, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_draw();
    exp_t        e;
    logic [15:0] l;
    int          slot;
    int          k = 0;
    l     = m_lfsr;
    e.lat = 2;
    if (m_left == 0) begin
      model_clear();
      e.lat = 3;
      l     = lfsr_step(l);
    end
    slot = start_of(l);
    while (m_used[slot]) begin
      slot = (slot + 1) % 52;
      k++;
    end
    m_used[slot] = 1'b1;
    m_left--;
    e.card  = slot % 13 + 1;
    e.left  = m_left;
    e.lat  += k;
    e.issue = cyc;
    last_k  = k;
    exp_q.push_back(e);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    chk("busy_after_draw", int'(busy), 1);
    wait_idle();
  endtask

  task automatic do_shuffle(input bit with_draw);
    model_clear();
    shuffle = 1'b1;
    draw    = with_draw;
    @(negedge clk);
    shuffle = 1'b0;
    draw    = 1'b0;
    wait_idle();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    int free_slot;
    int n;
    int p0;
    foreach (hist[i]) hist[i] = 0;
    model_clear();
    resetn  = 1'b0;
    draw    = 1'b0;
    shuffle = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_card", int'(card), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_left", int'(cards_left), 52);
    chk("rst_empty", int'(empty), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single draw straight after reset.
    do_draw();
    chk("first_left", int'(cards_left), 51);

    // Full deck: every rank four times, then empty.
    do_shuffle(1'b0);
    chk("shuffle_left", int'(cards_left), 52);
    foreach (hist[i]) hist[i] = 0;
    p0 = pulses;
    for (int i = 0; i < 52; i++) begin
      gap();
      do_draw();
    end
    chk("deck_pulses", pulses - p0, 52);
    for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), hist[r], 4);
    chk("empty_flag", int'(empty), 1);
    chk("empty_left", int'(cards_left), 0);

    // Draw from an empty shoe triggers an automatic shuffle.
    do_draw();
    chk("empty_draw_latency", obs_lat, 3 + last_k);
    chk("empty_draw_left", int'(cards_left), 51);

    // Pre-deal 51 cards and start one past the free slot to force a full wrap.
    free_slot = 51;
    for (int attempt = 0; attempt < 4 && free_slot == 51; attempt++) begin
      do_shuffle(1'b0);
      for (int i = 0; i < 51; i++) do_draw();
      foreach (m_used[i]) if (!m_used[i]) free_slot = i;
    end
    n = 0;
    while (start_of(m_lfsr) != (free_slot + 1) % 52 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("start_search_timeout", int'(n >= 3000), 0);
    do_draw();
    chk("wrap_latency", obs_lat, 53);
    chk("wrap_empty", int'(empty), 1);

    // Shuffle together with draw at ten cards left: draw dropped.
    do_shuffle(1'b0);
    for (int i = 0; i < 42; i++) do_draw();
    chk("ten_left", int'(cards_left), 10);
    p0 = pulses;
    do_shuffle(1'b1);
    repeat (4) @(negedge clk);
    chk("shuf_draw_left", int'(cards_left), 52);
    chk("shuf_draw_no_valid", pulses - p0, 0);

    // Randomized mix of draws and shuffles.
    for (int i = 0; i < 40; i++) begin
      gap();
      if ($urandom_range(0, 9) == 0) do_shuffle($urandom_range(0, 1) == 1);
      else                           do_draw();
    end

    // Reset during SEEK aborts the deal.
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    chk("seek_busy", int'(busy), 1);
    resetn = 1'b0;
    model_clear();
    p0 = pulses;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_valid", int'(card_valid), 0);
    chk("abort_left", int'(cards_left), 52);
    chk("abort_busy", int'(busy), 0);
    chk("abort_lfsr", int'(dut.u_lfsr.value), int'(SEED));
    repeat (4) @(negedge clk);
    chk("abort_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 5; i++) begin
      gap();
      do_draw();
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
